// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO control unit: default parameter values and
// the per-cycle operation encoding used to update the occupancy count.
package fifo_ctrl_pkg;

  localparam int DEFAULT_WIDTH     = 4;
  localparam int DEFAULT_WORD_LINE = 3;
  localparam int DEFAULT_SCAN_DIV  = 100000;

  // Which queue operations were accepted this cycle.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_DEQ  = 2'b01,
    OP_ENQ  = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic op_e op_decode(input logic enq_ok, input logic deq_ok);
    return op_e'({enq_ok, deq_ok});
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Bus between the FIFO controller and its surroundings: the debounced
// push-button requests, the register-file ports and the display-scan outputs.
interface fifo_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int WORD_LINE = DEFAULT_WORD_LINE
);

  logic                 enq;
  logic                 deq;
  logic [WIDTH-1:0]     in;
  logic [WIDTH-1:0]     out;
  logic                 full;
  logic                 empty;
  logic                 we;
  logic [WORD_LINE-1:0] wa;
  logic [WIDTH-1:0]     wd;
  logic [WORD_LINE-1:0] ra0;
  logic [WIDTH-1:0]     rd0;
  logic [WORD_LINE-1:0] ra1;
  logic [WIDTH-1:0]     rd1;
  logic [WORD_LINE-1:0] scan_addr;
  logic [WIDTH-1:0]     scan_data;
  logic                 scan_valid;

  // Environment side: buttons, register file and display driver.
  modport master (
    output enq, deq, in, rd0, rd1,
    input  out, full, empty, we, wa, wd, ra0, ra1,
           scan_addr, scan_data, scan_valid
  );

  // Controller side.
  modport slave (
    input  enq, deq, in, rd0, rd1,
    output out, full, empty, we, wa, wd, ra0, ra1,
           scan_addr, scan_data, scan_valid
  );

endinterface

// File: rtl/fifo_ctrl_edge_pulse.sv
// One-bit rising-edge detector. The history flop resets high so that an
// input already held high when reset is released does not produce a pulse.
module fifo_ctrl_edge_pulse
  import fifo_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic pulse_o
);

  logic sig_d;
  logic sig_q;

  // Next history value is simply the current input level.
  always_comb begin
    sig_d = sig_i;
  end

  // History register, sampled every cycle.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) sig_q <= 1'b1;
    else     sig_q <= sig_d;
  end

  assign pulse_o = sig_i & ~sig_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Control unit that turns a dual-read / single-write register file into a
// circular FIFO. Owns head/tail pointers, occupancy count and the per-slot
// valid map; read port 1 is lent to a free-running display scanner.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int WORD_LINE = DEFAULT_WORD_LINE,
  parameter int SCAN_DIV  = DEFAULT_SCAN_DIV
) (
  input logic       clk,
  input logic       rst,
  fifo_ctrl_if.slave bus
);

  localparam int DEPTH = 1 << WORD_LINE;
  localparam int CNT_W = WORD_LINE + 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);

  logic enq_p;
  logic deq_p;
  logic enq_ok;
  logic deq_ok;
  logic full;
  logic empty;
  op_e  op;

  logic [WORD_LINE-1:0] head_q, head_d;
  logic [WORD_LINE-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [WORD_LINE-1:0] scan_addr_q, scan_addr_d;
  logic [DIV_W-1:0]     div_q, div_d;

  fifo_ctrl_edge_pulse u_enq_edge (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (bus.enq),
    .pulse_o (enq_p)
  );

  fifo_ctrl_edge_pulse u_deq_edge (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (bus.deq),
    .pulse_o (deq_p)
  );

  // A dequeue frees a slot in the same cycle, so a full queue still takes an enqueue.
  always_comb begin
    full   = (count_q == CNT_FULL);
    empty  = (count_q == '0);
    deq_ok = deq_p & ~empty;
    enq_ok = enq_p & (~full | deq_ok);
    op     = op_decode(enq_ok, deq_ok);
  end

  // Queue next state: pointers, valid map, registered output word and count.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    out_d   = out_q;
    count_d = count_q;

    // Clear before set: when both hit the same slot (full queue) it stays valid.
    if (deq_ok) begin
      out_d           = bus.rd0;
      head_d          = head_q + 1'b1;
      valid_d[head_q] = 1'b0;
    end
    if (enq_ok) begin
      tail_d          = tail_q + 1'b1;
      valid_d[tail_q] = 1'b1;
    end

    case (op)
      OP_ENQ:  count_d = count_q + CNT_W'(1);
      OP_DEQ:  count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Display scanner: advance one slot every SCAN_DIV cycles.
  always_comb begin
    scan_addr_d = scan_addr_q;
    div_d       = div_q + 1'b1;
    if (div_q == DIV_LAST) begin
      div_d       = '0;
      scan_addr_d = scan_addr_q + 1'b1;
    end
  end

  // State register; register-file contents are left alone, the valid map hides them.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      out_q       <= '0;
      scan_addr_q <= '0;
      div_q       <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      out_q       <= out_d;
      scan_addr_q <= scan_addr_d;
      div_q       <= div_d;
    end
  end

  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.we         = enq_ok;
  assign bus.wa         = tail_q;
  assign bus.wd         = bus.in;
  assign bus.ra0        = head_q;
  assign bus.ra1        = scan_addr_q;
  assign bus.out        = out_q;
  assign bus.scan_addr  = scan_addr_q;
  assign bus.scan_data  = bus.rd1;
  assign bus.scan_valid = valid_q[scan_addr_q];

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural register file attached.
module tb_fifo_ctrl;

  localparam int WIDTH     = 4;
  localparam int WORD_LINE = 3;
  localparam int SCAN_DIV  = 2;

  logic clk;
  logic rst;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the scanner position.
  int m_div  = 0;
  int m_addr = 0;

  logic [WIDTH-1:0] mem [8];
  logic [WIDTH-1:0] slot_exp [8];

  fifo_ctrl_if #(.WIDTH(WIDTH), .WORD_LINE(WORD_LINE)) bus ();

  fifo_ctrl #(
    .WIDTH     (WIDTH),
    .WORD_LINE (WORD_LINE),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file: synchronous write, combinational reads.
  always @(posedge clk) begin
    if (bus.we) mem[bus.wa] <= bus.wd;
  end
  assign bus.rd0 = mem[bus.ra0];
  assign bus.rd1 = mem[bus.ra1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    if (r) begin
      m_div  = 0;
      m_addr = 0;
    end else if (m_div == SCAN_DIV - 1) begin
      m_div  = 0;
      m_addr = (m_addr + 1) % 8;
    end else begin
      m_div++;
    end
  endtask

  task automatic do_enq(input logic [WIDTH-1:0] v);
    bus.in  = v;
    bus.enq = 1'b1;
    tick();
    bus.enq = 1'b0;
    tick();
  endtask

  task automatic do_deq();
    bus.deq = 1'b1;
    tick();
    bus.deq = 1'b0;
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    rst     = 1'b1;
    bus.enq = 1'b1;
    bus.deq = 1'b0;
    bus.in  = 4'h7;

    // Reset state, with enq held high across reset.
    tick();
    tick();
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_out", bus.out, 0);
    check("rst_count", dut.count_q, 0);
    check("rst_valid", dut.valid_q, 0);
    check("rst_scan_addr", bus.scan_addr, 0);
    rst = 1'b0;
    tick();
    check("held_enq_count", dut.count_q, 0);
    check("held_enq_empty", bus.empty, 1);
    bus.enq = 1'b0;
    tick();

    // Fill 1..8, then a dropped 9th enqueue.
    for (int i = 1; i <= 8; i++) begin
      do_enq(4'(i));
      if (i == 7) check("fill7_full", bus.full, 0);
    end
    check("fill_full", bus.full, 1);
    check("fill_empty", bus.empty, 0);
    check("fill_count", dut.count_q, 8);
    check("fill_valid", dut.valid_q, 8'hFF);
    check("fill_tail", dut.tail_q, 0);
    do_enq(4'hF);
    check("drop_count", dut.count_q, 8);
    check("drop_tail", dut.tail_q, 0);
    check("drop_head", dut.head_q, 0);
    check("drop_mem0", mem[0], 1);

    // Drain in order, then a dropped dequeue.
    for (int i = 1; i <= 8; i++) begin
      do_deq();
      check("drain_out", bus.out, i);
    end
    check("drain_empty", bus.empty, 1);
    check("drain_count", dut.count_q, 0);
    check("drain_valid", dut.valid_q, 0);
    do_deq();
    check("extra_deq_out", bus.out, 8);
    check("extra_deq_head", dut.head_q, 0);

    // Ping-pong across the pointer wrap.
    for (int i = 0; i < 10; i++) begin
      do_enq(4'h5);
      check("pp_count1", dut.count_q, 1);
      check("pp_full", bus.full, 0);
      do_deq();
      check("pp_out", bus.out, 5);
      check("pp_count0", dut.count_q, 0);
    end
    check("pp_head", dut.head_q, 2);
    check("pp_tail", dut.tail_q, 2);

    // Simultaneous enq/deq on empty: only the enqueue lands.
    pulse_rst();
    tick();
    check("rst2_out", bus.out, 0);
    check("rst2_count", dut.count_q, 0);
    bus.in  = 4'hA;
    bus.enq = 1'b1;
    bus.deq = 1'b1;
    tick();
    check("both_empty_count", dut.count_q, 1);
    check("both_empty_out", bus.out, 0);
    check("both_empty_valid", dut.valid_q, 8'h01);
    check("both_empty_empty", bus.empty, 0);
    bus.enq = 1'b0;
    bus.deq = 1'b0;
    tick();
    do_deq();
    check("both_empty_deq_out", bus.out, 4'hA);
    check("both_empty_deq_count", dut.count_q, 0);

    // Simultaneous enq/deq on full: both land, count stays at depth.
    pulse_rst();
    tick();
    for (int i = 1; i <= 8; i++) do_enq(4'(i));
    bus.in  = 4'hC;
    bus.enq = 1'b1;
    bus.deq = 1'b1;
    tick();
    check("both_full_out", bus.out, 1);
    check("both_full_count", dut.count_q, 8);
    check("both_full_full", bus.full, 1);
    check("both_full_mem0", mem[0], 4'hC);
    check("both_full_head", dut.head_q, 1);
    check("both_full_tail", dut.tail_q, 1);
    check("both_full_valid", dut.valid_q, 8'hFF);
    bus.enq = 1'b0;
    bus.deq = 1'b0;
    tick();

    // Scan walk over a full queue: every slot valid with known contents.
    slot_exp[0] = 4'hC;
    for (int i = 1; i < 8; i++) slot_exp[i] = 4'(i + 1);
    for (int i = 0; i < 16; i++) begin
      check("scan_full_addr", bus.scan_addr, m_addr);
      check("scan_full_valid", bus.scan_valid, 1);
      check("scan_full_data", bus.scan_data, slot_exp[m_addr]);
      tick();
    end

    // enq held high through reset release, then reset with 3 entries queued.
    rst     = 1'b1;
    bus.enq = 1'b1;
    bus.in  = 4'h7;
    tick();
    rst = 1'b0;
    tick();
    check("held2_count", dut.count_q, 0);
    check("held2_empty", bus.empty, 1);
    bus.enq = 1'b0;
    tick();
    do_enq(4'h9);
    do_deq();
    check("pre_rst_out", bus.out, 9);
    do_enq(4'h1);
    do_enq(4'h2);
    do_enq(4'h3);
    check("pre_rst_count", dut.count_q, 3);
    pulse_rst();
    check("post_rst_empty", bus.empty, 1);
    check("post_rst_out", bus.out, 0);
    check("post_rst_count", dut.count_q, 0);
    check("post_rst_head", dut.head_q, 0);
    check("post_rst_tail", dut.tail_q, 0);
    for (int i = 0; i < 16; i++) begin
      check("scan_rst_addr", bus.scan_addr, m_addr);
      check("scan_rst_valid", bus.scan_valid, 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control unit that turns the dual-read / single-write register file into an 8-entry circular FIFO. It owns the head/tail pointers, occupancy count and per-slot valid map, and generates all register-file address/enable signals. A second read port is time-multiplexed for a display scanner. It sits between the debounced push-button/switch inputs and the register file plus display driver.

## Interface
- WIDTH, 4, data word width (must match the register file)
- WORD_LINE, 3, address width; DEPTH = 1 << WORD_LINE entries
- SCAN_DIV, 100000, clock cycles per display-scan step (≥ 1)

- clk  input  1  system clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- enq  input  1  enqueue request, level (debounced); acted on at rising edge
- deq  input  1  dequeue request, level (debounced); acted on at rising edge
- in  input  WIDTH  data to enqueue
- out  output  WIDTH  last dequeued word, registered
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- we  output  1  register-file write enable
- wa  output  WORD_LINE  register-file write address (= tail)
- wd  output  WIDTH  register-file write data (= in)
- ra0  output  WORD_LINE  read address 0 (= head)
- rd0  input  WIDTH  read data 0 (combinational from register file)
- ra1  output  WORD_LINE  read address 1 (= scan_addr)
- rd1  input  WIDTH  read data 1
- scan_addr  output  WORD_LINE  slot currently shown on display
- scan_data  output  WIDTH  = rd1
- scan_valid  output  1  = valid[scan_addr]

## Operation
- Edge detect: enq_p = enq & ~enq_q, deq_p = deq & ~deq_q; enq_q/deq_q register the inputs every cycle.
- Accept rules: enq_ok = enq_p & (~full | deq_ok); deq_ok = deq_p & ~empty.
- enq_ok: we = 1 (combinational, same cycle), wa = tail, wd = in; at edge tail <= tail+1 (mod DEPTH), valid[tail] <= 1.
- deq_ok: out <= rd0 (value at head before edge); head <= head+1 (mod DEPTH); valid[head] <= 0 unless the same slot is written in the same cycle.
- count: +1 on enq_ok only, −1 on deq_ok only, unchanged on both/neither; width WORD_LINE+1.
- Simultaneous on empty: deq ignored, enq accepted.
- Simultaneous on full: both accepted; out gets old head word, new word written at tail (== old head); count stays DEPTH.
- Enq on full (no deq) and deq on empty (no enq): dropped, no state change, out holds.
- Pointers wrap DEPTH-1 → 0 with no special case.
- Scan: divider counts 0..SCAN_DIV-1; at terminal count scan_addr <= scan_addr+1 (wraps). Independent of enq/deq.

## Timing
- Reset values: head = tail = 0, count = 0, valid = 0, out = 0, scan_addr = 0, divider = 0, enq_q = deq_q = 1 (an input held high across reset does not fire).
- full/empty/we/wa/wd/ra0/ra1/scan_* are combinational from registered state and inputs; no registered output besides out and scan_addr.
- Latency: enq rising edge at cycle N → word in register file, full/empty updated after edge N. deq rising edge at cycle N → out valid after edge N.
- At most one enq and one deq per input rising edge; input held high = one operation.
- rst asserted mid-operation: all state returns to reset values at the next edge; register-file contents are not cleared (valid map hides them).

## Structure
- DEPTH localparam and count width derived in module; no shared package needed beyond the existing parameter convention.
- One sub-module: edge_pulse (1-bit rising-edge detector, reset value 1), instantiated for enq and deq.
- Register file instantiated by the parent with WIDTH/WORD_LINE passed through.

## Test plan
- Reset then enq 1,2,...,8 (one rising edge each) → full = 1 after 8th, count 8, valid = 8'hFF; 9th enq (value F) dropped, tail stays 0.
- Deq 8 times from full → out sequence 1..8, empty = 1 after last; extra deq leaves out = 8.
- Enq 5 / deq 5 repeated 10 times → pointers wrap, out always 5, count toggles 1/0, no full.
- Empty, enq (value A) and deq edges in same cycle → count 1, out unchanged, valid[0] = 1.
- Full with slots holding 1..8, enq (value C) and deq in same cycle → out = 1, count 8, slot 0 holds C, head = tail = 1.
- enq held high through rst deassert → no enqueue; rst pulsed with 3 entries → empty = 1, out = 0, scan_valid = 0 for all addresses (SCAN_DIV = 2 scan walks 0..7).
